// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end for a command/address/data register port.
// Each SS_n-framed transaction carries a 10-bit frame, MSB first, where
// [9:8] is the command and [7:0] is the address or data. The received frame
// is strobed out on rx_valid. A read-data frame then waits for tx_valid and
// shifts tx_data out on MISO, MSB first.
//
// Ports:
//   clk       - SPI serial clock; all logic runs on its rising edge
//   rst_n     - asynchronous active-low reset
//   SS_n      - slave select, active-low; a high level aborts any transaction
//   MOSI      - serial data in, MSB first
//   MISO      - serial read data out, MSB first; 0 when nothing is shifting
//   rx_data   - last received frame, held between strobes
//   rx_valid  - one-cycle strobe qualifying rx_data
//   tx_data   - read data from the memory side
//   tx_valid  - qualifies tx_data while a read is waiting for it
//
// Build option:
//   SPI_RD_TIMEOUT_EN - when defined, a read that sees no tx_valid within
//                       TIMEOUT_CYC cycles after its rx_valid is abandoned.
//                       When undefined, the read waits for as long as SS_n
//                       stays low.
module spi_slave #(
   parameter int unsigned TIMEOUT_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SS_n,
   input  logic       MOSI,
   output logic       MISO,
   output logic [9:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid
);

   localparam int unsigned FRAME_W = 10;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] CHK_CMD   = 3'd1;
   localparam logic [STATE_W-1:0] WRITE     = 3'd2;
   localparam logic [STATE_W-1:0] READ_ADD  = 3'd3;
   localparam logic [STATE_W-1:0] READ_DATA = 3'd4;
   localparam logic [STATE_W-1:0] DONE      = 3'd5;

   // bit_cnt reaches LAST_BIT once bits 8..0 are in; READ_DATA parks it at
   // RD_TAIL for the wait/shift-out phase that follows its rx_valid.
   localparam logic [CNT_W-1:0] LAST_BIT = 4'd9;
   localparam logic [CNT_W-1:0] RD_TAIL  = 4'd10;
   localparam logic [2:0]       TX_LAST  = 3'd7;

   logic [STATE_W-1:0] state, state_d;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
   logic [FRAME_W-1:0] shift, shift_d;
   logic [FRAME_W-1:0] rx_data_d;
   logic               rx_valid_d;
   logic               miso_d;
   logic               rd_addr_seen, rd_addr_seen_d;
   logic [BYTE_W-1:0]  tx_shift, tx_shift_d;
   logic [2:0]         tx_cnt, tx_cnt_d;
   logic               tx_wait, tx_wait_d;
   logic               tx_busy, tx_busy_d;

`ifdef SPI_RD_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TO_W-1:0] to_cnt, to_cnt_d;
`else
   // TIMEOUT_CYC only has an effect when the timeout is compiled in
   logic timeout_unused;
   assign timeout_unused = |TIMEOUT_CYC;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         MISO         <= 1'b0;
         rd_addr_seen <= 1'b0;
         tx_shift     <= '0;
         tx_cnt       <= '0;
         tx_wait      <= 1'b0;
         tx_busy      <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
         to_cnt       <= '0;
`endif
      end else begin
         state        <= state_d;
         bit_cnt      <= bit_cnt_d;
         shift        <= shift_d;
         rx_data      <= rx_data_d;
         rx_valid     <= rx_valid_d;
         MISO         <= miso_d;
         rd_addr_seen <= rd_addr_seen_d;
         tx_shift     <= tx_shift_d;
         tx_cnt       <= tx_cnt_d;
         tx_wait      <= tx_wait_d;
         tx_busy      <= tx_busy_d;
`ifdef SPI_RD_TIMEOUT_EN
         to_cnt       <= to_cnt_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state;
      bit_cnt_d      = bit_cnt;
      shift_d        = shift;
      rx_data_d      = rx_data;
      rx_valid_d     = 1'b0;
      miso_d         = 1'b0;
      rd_addr_seen_d = rd_addr_seen;
      tx_shift_d     = tx_shift;
      tx_cnt_d       = tx_cnt;
      tx_wait_d      = tx_wait;
      tx_busy_d      = tx_busy;
`ifdef SPI_RD_TIMEOUT_EN
      to_cnt_d       = to_cnt;
`endif

      if (SS_n) begin
         // Deselect wins everywhere; rd_addr_seen deliberately survives
         state_d   = IDLE;
         bit_cnt_d = '0;
         tx_cnt_d  = '0;
         tx_wait_d = 1'b0;
         tx_busy_d = 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
         to_cnt_d  = '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state_d   = CHK_CMD;
               bit_cnt_d = '0;
            end

            CHK_CMD: begin
               shift_d   = {MOSI, 9'd0};
               bit_cnt_d = '0;
               if (!MOSI)             state_d = WRITE;
               else if (rd_addr_seen) state_d = READ_DATA;
               else                   state_d = READ_ADD;
            end

            WRITE, READ_ADD, READ_DATA: begin
               if (bit_cnt < LAST_BIT) begin
                  // shift[9] keeps bit 9; bits 8..0 fill from the right
                  shift_d   = {shift[9], shift[7:0], MOSI};
                  bit_cnt_d = bit_cnt + 4'd1;
               end else if (bit_cnt == LAST_BIT) begin
                  rx_data_d  = shift;
                  rx_valid_d = 1'b1;
                  if (state == READ_DATA) begin
                     rd_addr_seen_d = 1'b0;
                     bit_cnt_d      = RD_TAIL;
                     tx_wait_d      = 1'b1;
`ifdef SPI_RD_TIMEOUT_EN
                     to_cnt_d       = '0;
`endif
                  end else begin
                     state_d = DONE;
                     if (state == READ_ADD) rd_addr_seen_d = 1'b1;
                  end
               end else if (tx_wait) begin
                  if (tx_valid) begin
                     tx_shift_d = tx_data;
                     tx_wait_d  = 1'b0;
                     tx_busy_d  = 1'b1;
                     tx_cnt_d   = '0;
                  end
`ifdef SPI_RD_TIMEOUT_EN
                  else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                     tx_wait_d = 1'b0;
                     state_d   = DONE;
                  end else begin
                     to_cnt_d = to_cnt + TO_W'(1);
                  end
`endif
               end else if (tx_busy) begin
                  miso_d     = tx_shift[7];
                  tx_shift_d = {tx_shift[6:0], 1'b0};
                  tx_cnt_d   = tx_cnt + 3'd1;
                  if (tx_cnt == TX_LAST) begin
                     tx_busy_d = 1'b0;
                     state_d   = DONE;
                  end
               end else begin
                  state_d = DONE;
               end
            end

            DONE: begin
               state_d = DONE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule
